motion_search_ctrl: RTL and testbench

Sequences the block-compare datapath over a square search window of candidate motion vectors for one macroblock. It issues one compare run per candidate and supplies the running best SAD as the compare threshold, so the datapath aborts early on worse candidates. It records the winning vector, then re-runs the winner once so its residual is written out.
Sits between the encoder top-level FSM (start/done) and the block comparator; it also drives the candidate offset to the previous-frame fetcher.

---
 rtl/motion_pkg.sv | 23 ++
 rtl/search_window_iter.sv | 51 +++++
 rtl/motion_search_ctrl.sv | 145 ++++++++++++++
 tb/tb_motion_search_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/motion_pkg.sv
// Shared types and defaults for the motion-search controller and its window iterator.
package motion_pkg;

    localparam int RANGE_DEF = 7;
    localparam int VW_DEF    = 5;
    localparam int SW_DEF    = 18;

    // Largest positive SAD. The comparator compares signed values, so this is the
    // "never abort" threshold.
    localparam logic [SW_DEF-1:0] SAD_MAX = 18'h1FFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_RUN,
        S_EVAL,
        S_NEXT,
        S_RISSUE,
        S_RRUN,
        S_FIN
    } ms_state_e;

endpackage

// File: rtl/search_window_iter.sv
// Raster counter over the square search window: dy is the outer loop and dx the inner.
// Supports init to the first corner, a single raster step, and a direct load, which is
// used to point the fetcher back at the winning vector.
module search_window_iter #(
    parameter int RANGE = 7,
    parameter int VW    = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 init_i,
    input  logic                 step_i,
    input  logic                 load_i,
    input  logic signed [VW-1:0] load_dx_i,
    input  logic signed [VW-1:0] load_dy_i,
    output logic signed [VW-1:0] dx_o,
    output logic signed [VW-1:0] dy_o,
    output logic                 last_o
);

    localparam logic signed [VW-1:0] RMAX = VW'(RANGE);
    localparam logic signed [VW-1:0] RMIN = VW'(-RANGE);
    localparam logic signed [VW-1:0] ONE  = VW'(1);

    logic signed [VW-1:0] dx_q, dy_q;

    // Candidate position: init has priority over load, and load has priority over step.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dx_q <= '0;
            dy_q <= '0;
        end else if (init_i) begin
            dx_q <= RMIN;
            dy_q <= RMIN;
        end else if (load_i) begin
            dx_q <= load_dx_i;
            dy_q <= load_dy_i;
        end else if (step_i) begin
            if (dx_q == RMAX) begin
                dx_q <= RMIN;
                dy_q <= dy_q + ONE;
            end else begin
                dx_q <= dx_q + ONE;
            end
        end
    end

    assign dx_o   = dx_q;
    assign dy_o   = dy_q;
    assign last_o = (dx_q == RMAX) && (dy_q == RMAX);

endmodule

// File: rtl/motion_search_ctrl.sv
// Full-search motion controller. It issues one comparator run per candidate and feeds
// the running best SAD back as the abort threshold. It then re-runs the winner once
// with the threshold forced open, so the residual is captured downstream.
module motion_search_ctrl
    import motion_pkg::*;
#(
    parameter int RANGE = RANGE_DEF,
    parameter int VW    = VW_DEF,
    parameter int SW    = SW_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [SW-1:0]        thresh,
    output logic                 busy,
    output logic                 done,
    output logic signed [VW-1:0] cand_dx,
    output logic signed [VW-1:0] cand_dy,
    output logic                 cmp_en,
    input  logic                 cmp_rdy,
    input  logic                 cmp_valid,
    input  logic [SW-1:0]        cmp_accum,
    output logic [SW-1:0]        cmp_oldaccum,
    output logic                 res_capture,
    output logic signed [VW-1:0] best_dx,
    output logic signed [VW-1:0] best_dy,
    output logic [SW-1:0]        best_sad
);

    localparam logic [SW-1:0] SAD_MAX_W = {1'b0, {(SW-1){1'b1}}};

    ms_state_e            state_q;
    logic                 first_q;      // masks cmp_rdy in the first RUN/RRUN cycle
    logic                 busy_q, done_q, rc_q;
    logic signed [VW-1:0] best_dx_q, best_dy_q;
    logic [SW-1:0]        best_sad_q, old_q;

    logic                 it_init, it_step, it_load, it_last, stop;
    logic signed [VW-1:0] it_dx, it_dy;

    search_window_iter #(.RANGE(RANGE), .VW(VW)) u_iter (
        .clk       (clk),
        .reset_n   (reset_n),
        .init_i    (it_init),
        .step_i    (it_step),
        .load_i    (it_load),
        .load_dx_i (best_dx_q),
        .load_dy_i (best_dy_q),
        .dx_o      (it_dx),
        .dy_o      (it_dy),
        .last_o    (it_last)
    );

    // Leave the search after a good-enough match or after the last candidate.
    assign stop    = (best_sad_q <= thresh) || it_last;
    assign it_init = (state_q == S_IDLE) && start;
    assign it_step = (state_q == S_NEXT) && !stop;
    assign it_load = (state_q == S_NEXT) && stop;

    // Sequencer. State, best-match tracking and the registered handshake outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            first_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rc_q       <= 1'b0;
            best_dx_q  <= '0;
            best_dy_q  <= '0;
            best_sad_q <= '0;
            old_q      <= SAD_MAX_W;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: if (start) begin
                    busy_q     <= 1'b1;
                    best_sad_q <= SAD_MAX_W;
                    best_dx_q  <= '0;
                    best_dy_q  <= '0;
                    old_q      <= SAD_MAX_W;
                    state_q    <= S_ISSUE;
                end
                S_ISSUE: if (cmp_rdy) begin
                    first_q <= 1'b1;
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    if (first_q)      first_q <= 1'b0;
                    else if (cmp_rdy) state_q <= S_EVAL;
                end
                S_EVAL: begin
                    // Strict compare: on a tie, the earlier raster candidate is kept.
                    if (cmp_valid && (cmp_accum < best_sad_q)) begin
                        best_sad_q <= cmp_accum;
                        best_dx_q  <= it_dx;
                        best_dy_q  <= it_dy;
                        old_q      <= cmp_accum;
                    end
                    state_q <= S_NEXT;
                end
                S_NEXT: begin
                    if (stop) begin
                        rc_q    <= 1'b1;
                        old_q   <= SAD_MAX_W;   // the residual pass must never abort
                        state_q <= S_RISSUE;
                    end else begin
                        state_q <= S_ISSUE;
                    end
                end
                S_RISSUE: if (cmp_rdy) begin
                    first_q <= 1'b1;
                    state_q <= S_RRUN;
                end
                S_RRUN: begin
                    if (first_q) begin
                        first_q <= 1'b0;
                    end else if (cmp_rdy) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        rc_q    <= 1'b0;
                        old_q   <= best_sad_q;
                        state_q <= S_FIN;
                    end
                end
                S_FIN:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Launch is gated by the live cmp_rdy, so an enable can never meet a busy comparator.
    // Each issue state is left on the same edge, which keeps the pulse to one cycle.
    assign cmp_en = ((state_q == S_ISSUE) || (state_q == S_RISSUE)) && cmp_rdy;

    assign busy         = busy_q;
    assign done         = done_q;
    assign res_capture  = rc_q;
    assign cand_dx      = it_dx;
    assign cand_dy      = it_dy;
    assign cmp_oldaccum = old_q;
    assign best_dx      = best_dx_q;
    assign best_dy      = best_dy_q;
    assign best_sad     = best_sad_q;

endmodule

// File: tb/tb_motion_search_ctrl.sv
// Scoreboard bench for motion_search_ctrl with RANGE=1 (3x3 window) and a behavioural comparator.
module tb_motion_search_ctrl;

    localparam int RANGE = 1;
    localparam int VW    = 5;
    localparam int SW    = 18;
    localparam int MAX   = 32'h1FFFF;

    logic                 clk, reset_n, start;
    logic [SW-1:0]        thresh;
    logic                 busy, done, cmp_en, cmp_rdy, cmp_valid, res_capture;
    logic signed [VW-1:0] cand_dx, cand_dy, best_dx, best_dy;
    logic [SW-1:0]        cmp_accum, cmp_oldaccum, best_sad;

    motion_search_ctrl #(.RANGE(RANGE), .VW(VW), .SW(SW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .thresh       (thresh),
        .busy         (busy),
        .done         (done),
        .cand_dx      (cand_dx),
        .cand_dy      (cand_dy),
        .cmp_en       (cmp_en),
        .cmp_rdy      (cmp_rdy),
        .cmp_valid    (cmp_valid),
        .cmp_accum    (cmp_accum),
        .cmp_oldaccum (cmp_oldaccum),
        .res_capture  (res_capture),
        .best_dx      (best_dx),
        .best_dy      (best_dy),
        .best_sad     (best_sad)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking bookkeeping ----------------
    int n_chk = 0, n_fail = 0;
    int en_cnt = 0, done_cnt = 0;

    typedef struct {
        bit is_done;
        int dx;
        int dy;
        int val;   // oldaccum for a launch, best_sad for done
        bit rc;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic push_en(input int dx, input int dy, input int old, input bit rc);
        exp_t e;
        e.is_done = 0; e.dx = dx; e.dy = dy; e.val = old; e.rc = rc;
        q.push_back(e);
    endtask

    task automatic push_done(input int dx, input int dy, input int sad);
        exp_t e;
        e.is_done = 1; e.dx = dx; e.dy = dy; e.val = sad; e.rc = 0;
        q.push_back(e);
    endtask

    // Launch expectations for the 3x3 raster. The caller supplies the threshold
    // expected at each launch.
    task automatic push_raster(input int olds[9]);
        int k = 0;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++) begin
                push_en(dx, dy, olds[k], 0);
                k++;
            end
    endtask

    // ---------------- comparator model ----------------
    int   def_sad;
    int   sp_dx[2], sp_dy[2], sp_sad[2];
    bit   abort_mode, force_low;
    int   run_idx, lat_idx, cnt;
    logic rdy_q, pend;
    logic [SW-1:0] lat_sad, lat_old;

    function automatic int sad_of(input int dx, input int dy);
        for (int i = 0; i < 2; i++)
            if (sp_dx[i] == dx && sp_dy[i] == dy) return sp_sad[i];
        return def_sad;
    endfunction

    assign cmp_rdy = rdy_q & ~force_low;

    // rdy drops one cycle after en, then the result appears a few cycles later.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdy_q     <= 1'b1;
            pend      <= 1'b0;
            cnt       <= 0;
            cmp_valid <= 1'b0;
            cmp_accum <= '0;
        end else if (cmp_en) begin
            pend    <= 1'b1;
            lat_sad <= SW'(sad_of(int'(cand_dx), int'(cand_dy)));
            lat_old <= cmp_oldaccum;
            lat_idx <= run_idx + 1;
            run_idx <= run_idx + 1;
        end else if (pend) begin
            pend  <= 1'b0;
            rdy_q <= 1'b0;
            cnt   <= 3;
        end else if (!rdy_q) begin
            if (cnt == 0) begin
                rdy_q     <= 1'b1;
                cmp_accum <= lat_sad;
                cmp_valid <= (abort_mode && lat_idx > 1) ? 1'b0 : (lat_sad <= lat_old);
            end else begin
                cnt <= cnt - 1;
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (reset_n) begin
            if (cmp_en) begin
                en_cnt++;
                chk("en_needs_rdy", cmp_rdy, 1);
                if (q.size() == 0) begin
                    chk("unexpected_cmp_en", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("en_kind", e.is_done, 0);
                    chk("cand_dx", int'(cand_dx), e.dx);
                    chk("cand_dy", int'(cand_dy), e.dy);
                    chk("cmp_oldaccum", cmp_oldaccum, e.val);
                    chk("res_capture", res_capture, e.rc);
                end
            end
            if (done) begin
                done_cnt++;
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("done_kind", e.is_done, 1);
                    chk("best_dx", int'(best_dx), e.dx);
                    chk("best_dy", int'(best_dy), e.dy);
                    chk("best_sad", best_sad, e.val);
                    chk("done_busy", busy, 0);
                    chk("done_res_capture", res_capture, 0);
                    chk("done_oldaccum", cmp_oldaccum, e.val);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int base = done_cnt;
        int i = 0;
        while (done_cnt == base && i < 3000) begin
            @(posedge clk);
            i++;
        end
        chk({nm, "_done_seen"}, done_cnt - base, 1);
        repeat (4) @(posedge clk);
        chk({nm, "_single_done"}, done_cnt - base, 1);
        chk({nm, "_queue_empty"}, q.size(), 0);
    endtask

    task automatic set_table(input int d, input int x0, input int y0, input int s0,
                             input int x1, input int y1, input int s1);
        def_sad = d;
        sp_dx[0] = x0; sp_dy[0] = y0; sp_sad[0] = s0;
        sp_dx[1] = x1; sp_dy[1] = y1; sp_sad[1] = s1;
    endtask

    initial begin
        int base;
        start = 0; thresh = '0; reset_n = 0;
        abort_mode = 0; force_low = 0; run_idx = 0;
        set_table(100, 9, 9, 0, 9, 9, 0);
        repeat (2) @(negedge clk);
        // reset values
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cmp_en", cmp_en, 0);
        chk("rst_res_capture", res_capture, 0);
        chk("rst_cand_dx", int'(cand_dx), 0);
        chk("rst_best_dy", int'(best_dy), 0);
        chk("rst_best_sad", best_sad, 0);
        chk("rst_oldaccum", cmp_oldaccum, MAX);
        reset_n = 1;
        repeat (2) @(negedge clk);

        // T1: full sweep, the single minimum at (1,0)
        set_table(100, 1, 0, 40, 9, 9, 0);
        thresh = 0;
        push_raster('{MAX, 100, 100, 100, 100, 100, 40, 40, 40});
        push_en(1, 0, MAX, 1);
        push_done(1, 0, 40);
        do_start();
        chk("t1_busy", busy, 1);
        wait_done("t1");

        // T2: tie between (-1,-1) and (1,1); the first in raster order wins
        set_table(90, -1, -1, 50, 1, 1, 50);
        push_raster('{MAX, 50, 50, 50, 50, 50, 50, 50, 50});
        push_en(-1, -1, MAX, 1);
        push_done(-1, -1, 50);
        do_start();
        wait_done("t2");

        // T3: early exit once best_sad <= thresh
        set_table(100, 0, -1, 55, 9, 9, 0);
        thresh = 60;
        push_en(-1, -1, MAX, 0);
        push_en(0, -1, 100, 0);
        push_en(0, -1, MAX, 1);
        push_done(0, -1, 55);
        do_start();
        wait_done("t3");

        // T4: comparator aborts every run after the first
        set_table(10, -1, -1, 30, 9, 9, 0);
        thresh = 0;
        abort_mode = 1;
        @(negedge clk) run_idx = 0;
        push_raster('{MAX, 30, 30, 30, 30, 30, 30, 30, 30});
        push_en(-1, -1, MAX, 1);
        push_done(-1, -1, 30);
        do_start();
        wait_done("t4");
        abort_mode = 0;

        // T5: reset during the 4th compare run, then a clean restart
        set_table(100, 1, 0, 40, 9, 9, 0);
        push_en(-1, -1, MAX, 0);
        push_en(0, -1, 100, 0);
        push_en(1, -1, 100, 0);
        push_en(-1, 0, 100, 0);
        base = en_cnt;
        do_start();
        for (int i = 0; i < 500 && en_cnt < base + 4; i++) @(posedge clk);
        chk("t5_reached_4th", en_cnt - base, 4);
        @(negedge clk);
        #1 reset_n = 0;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_cmp_en", cmp_en, 0);
        chk("t5_oldaccum", cmp_oldaccum, MAX);
        chk("t5_cand_dx", int'(cand_dx), 0);
        chk("t5_best_sad", best_sad, 0);
        repeat (2) @(negedge clk);
        reset_n = 1;
        repeat (2) @(negedge clk);
        chk("t5_queue_empty_after_reset", q.size(), 0);
        push_raster('{MAX, 100, 100, 100, 100, 100, 40, 40, 40});
        push_en(1, 0, MAX, 1);
        push_done(1, 0, 40);
        do_start();
        wait_done("t5");

        // T6: rdy held low in ISSUE for 20 cycles, plus a start pulse while busy
        push_raster('{MAX, 100, 100, 100, 100, 100, 40, 40, 40});
        push_en(1, 0, MAX, 1);
        push_done(1, 0, 40);
        base = en_cnt;
        @(negedge clk) begin start = 1'b1; force_low = 1'b1; end
        @(negedge clk) start = 1'b0;
        repeat (20) @(negedge clk);
        chk("t6_no_en_while_stalled", en_cnt - base, 0);
        chk("t6_busy_stalled", busy, 1);
        force_low = 1'b0;
        repeat (30) @(negedge clk);
        do_start();
        wait_done("t6");
        chk("t6_en_total", en_cnt - base, 10);
        repeat (30) @(posedge clk);
        chk("t6_idle_after", busy, 0);
        chk("t6_no_extra_en", en_cnt - base, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
